// File: rtl/serial_frame_tx_pkg.sv
// Shared definitions for the serial frame transmitter: FSM state encoding
// and the bit-counter width derived from the word length.
package serial_frame_tx_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Counter must hold 0..width-1; width is at least 2, so this is never 0.
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame shifter. Words arrive on a valid/ready handshake
// and leave one bit per clock; a word offered during the last bit of the
// current word is chained in with no idle cycle, so the stream stays gap-free.
//
// Handshake: a word transfers on a rising edge where load_valid && load_ready
// && reset==1. load_ready depends only on registered state (idle, or last bit
// of a word), never on load_valid. A source seeing load_ready==0 must hold.
module serial_frame_tx
    import serial_frame_tx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int               CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic               last_bit;
    logic               accept;
    logic [WIDTH-1:0]   sh_shifted;

    // Output decode and handshake, from registered state only.
    always_comb begin
        last_bit     = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
        load_ready   = (state_q == ST_IDLE) || last_bit;
        accept       = load_valid && load_ready;
        serial_valid = (state_q == ST_SHIFT);
        busy         = (state_q == ST_SHIFT);
        frame_done   = last_bit;
        serial_out   = IDLE_BIT;
        if (state_q == ST_SHIFT) begin
            serial_out = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];
        end
        sh_shifted = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
    end

    // Next-state logic: load on transfer, shift mid-word, chain or stop at the last bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sh_d    = load_data;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!last_bit) begin
                    sh_d  = sh_shifted;
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (accept) begin
                    sh_d  = load_data;
                    cnt_d = '0;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State register; reset drops any partial word and blocks a same-edge transfer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: one MSB-first instance (idle level 0) and one
// LSB-first instance (idle level 1). Expected bits are queued when a word is
// offered; a negedge monitor pops and compares whenever serial_valid is high.
module tb_serial_frame_tx;

    localparam bit IDLE_A = 1'b0;
    localparam bit IDLE_B = 1'b1;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] load_data_a, load_data_b;
    logic       load_valid_a, load_valid_b;
    logic       load_ready_a, load_ready_b;
    logic       serial_out_a, serial_out_b;
    logic       serial_valid_a, serial_valid_b;
    logic       busy_a, busy_b;
    logic       frame_done_a, frame_done_b;

    int checks = 0;
    int errors = 0;

    // Entries are {frame_done expected, serial bit expected}.
    logic [1:0] exp_q_a[$];
    logic [1:0] exp_q_b[$];
    logic [1:0] e_a, e_b;

    serial_frame_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE_A)) dut_a (
        .clk(clk), .reset(reset), .load_data(load_data_a), .load_valid(load_valid_a),
        .load_ready(load_ready_a), .serial_out(serial_out_a), .serial_valid(serial_valid_a),
        .busy(busy_a), .frame_done(frame_done_a)
    );

    serial_frame_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(IDLE_B)) dut_b (
        .clk(clk), .reset(reset), .load_data(load_data_b), .load_valid(load_valid_b),
        .load_ready(load_ready_b), .serial_out(serial_out_b), .serial_valid(serial_valid_b),
        .busy(busy_b), .frame_done(frame_done_b)
    );

    // Clock and global watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // stream is the hand-written bit sequence in transmission order, first bit on the left.
    task automatic push_exp(input bit sel, input logic [7:0] stream);
        for (int k = 7; k >= 0; k--) begin
            if (sel) exp_q_b.push_back({(k == 0), stream[k]});
            else     exp_q_a.push_back({(k == 0), stream[k]});
        end
    endtask

    // Offer one word, wait (bounded) for acceptance, then drop load_valid.
    task automatic send(input bit sel, input logic [7:0] d, input logic [7:0] stream);
        int waited;
        waited = 0;
        if (sel) begin load_data_b = d; load_valid_b = 1'b1; end
        else     begin load_data_a = d; load_valid_a = 1'b1; end
        @(negedge clk);
        while (!(sel ? load_ready_b : load_ready_a) && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("accept_wait", sel ? load_ready_b : load_ready_a, 1);
        push_exp(sel, stream);
        @(posedge clk); #1;
        if (sel) load_valid_b = 1'b0;
        else     load_valid_a = 1'b0;
    endtask

    // Two words back-to-back on instance A; optionally toggle load_data mid-frame.
    task automatic stream_pair(input logic [7:0] w0, input logic [7:0] w1, input bit toggle);
        load_data_a  = w0;
        load_valid_a = 1'b1;
        @(negedge clk);
        check("pair_ready_idle", load_ready_a, 1);
        push_exp(1'b0, w0);
        @(posedge clk); #1;
        load_data_a = toggle ? 8'hAA : w1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (toggle && i < 7) load_data_a = (i % 2 == 0) ? 8'hAA : 8'h55;
            if (i == 7) begin
                load_data_a = w1;
                push_exp(1'b0, w1);
            end
            check("pair_valid", serial_valid_a, 1);
            check("pair_ready", load_ready_a, (i == 7 || i == 15));
            if (i == 15) load_valid_a = 1'b0;
        end
        @(negedge clk);
        check("pair_tail_idle", serial_valid_a, 0);
    endtask

    task automatic check_idle_a(input string name);
        check({name, "_valid"}, serial_valid_a, 0);
        check({name, "_out"}, serial_out_a, IDLE_A);
        check({name, "_busy"}, busy_a, 0);
        check({name, "_done"}, frame_done_a, 0);
        check({name, "_ready"}, load_ready_a, 1);
    endtask

    // Scoreboard monitor: compare every valid serial bit against the queue.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (serial_valid_a) begin
                if (exp_q_a.size() == 0) begin
                    check("a_unexpected_bit", serial_valid_a, 0);
                end else begin
                    e_a = exp_q_a.pop_front();
                    check("a_bit", serial_out_a, e_a[0]);
                    check("a_frame_done", frame_done_a, e_a[1]);
                    check("a_busy", busy_a, 1);
                end
            end else begin
                check("a_idle_out", serial_out_a, IDLE_A);
                check("a_idle_done", frame_done_a, 0);
            end
            if (serial_valid_b) begin
                if (exp_q_b.size() == 0) begin
                    check("b_unexpected_bit", serial_valid_b, 0);
                end else begin
                    e_b = exp_q_b.pop_front();
                    check("b_bit", serial_out_b, e_b[0]);
                    check("b_frame_done", frame_done_b, e_b[1]);
                    check("b_busy", busy_b, 1);
                end
            end else begin
                check("b_idle_out", serial_out_b, IDLE_B);
                check("b_idle_done", frame_done_b, 0);
            end
        end
    end

    // Directed stimulus.
    initial begin
        reset        = 1'b0;
        load_valid_a = 1'b0;
        load_valid_b = 1'b0;
        load_data_a  = 8'h00;
        load_data_b  = 8'h00;
        repeat (3) @(posedge clk);
        #1;

        // Reset state of both instances.
        @(negedge clk);
        check_idle_a("rst_a");
        check("rst_b_out", serial_out_b, IDLE_B);
        check("rst_b_valid", serial_valid_b, 0);
        check("rst_b_ready", load_ready_b, 1);
        @(posedge clk); #1;
        reset = 1'b1;

        // Single word MSB-first: 1011_0000, frame_done on the 8th bit, then idle.
        send(1'b0, 8'hB0, 8'b1011_0000);
        repeat (8) @(negedge clk);
        check("s1_last_done", frame_done_a, 1);
        @(negedge clk);
        check_idle_a("s1_after");

        // Back-to-back B5 then 6C with load_valid held: 16 contiguous bits.
        @(posedge clk); #1;
        stream_pair(8'hB5, 8'h6C, 1'b0);

        // Mid-frame data toggling is ignored; only the last-bit-cycle value is taken.
        @(posedge clk); #1;
        stream_pair(8'hC3, 8'h55, 1'b1);

        // Reset after the 3rd bit of FF discards the word.
        @(posedge clk); #1;
        send(1'b0, 8'hFF, 8'hFF);
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b0;
        exp_q_a.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_idle_a("s3_reset");
        @(posedge clk); #1;
        send(1'b0, 8'h0F, 8'b0000_1111);
        repeat (10) @(negedge clk);

        // LSB-first: 0D leaves as 1,0,1,1,0,0,0,0; idle level 1 afterwards.
        @(posedge clk); #1;
        send(1'b1, 8'h0D, 8'b1011_0000);
        repeat (8) @(negedge clk);
        check("s4_last_done", frame_done_b, 1);
        @(negedge clk);
        check("s4_after_valid", serial_valid_b, 0);
        check("s4_after_out", serial_out_b, IDLE_B);

        // Reset in the same edge as a valid word: nothing accepted.
        @(posedge clk); #1;
        reset        = 1'b0;
        load_data_a  = 8'hFF;
        load_valid_a = 1'b1;
        @(posedge clk); #1;
        reset        = 1'b1;
        load_valid_a = 1'b0;
        @(negedge clk);
        check_idle_a("s6_after");
        repeat (4) @(negedge clk);
        check("s6_still_idle", serial_valid_a, 0);

        check("a_queue_empty", exp_q_a.size(), 0);
        check("b_queue_empty", exp_q_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
